ir_nec_tx: RTL



---
 rtl/ir_pkg.sv | 34 +++
 rtl/ir_nec_tx_if.sv | 14 +
 rtl/ir_unit_timer.sv | 37 +++
 rtl/ir_nec_tx.sv | 104 ++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// ir_pkg: NEC frame constants and state encoding shared by the IR transmitter and receiver.
package ir_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEAD_MARK,
      LEAD_SPACE,
      BIT_MARK,
      BIT_SPACE,
      STOP_MARK
   } ir_state_t;

   localparam int LEAD_MARK_UNITS  = 16;
   localparam int LEAD_SPACE_UNITS = 8;
   localparam int BIT_MARK_UNITS   = 1;
   localparam int ZERO_SPACE_UNITS = 1;
   localparam int ONE_SPACE_UNITS  = 3;
   localparam int STOP_UNITS       = 1;
   localparam int FRAME_BITS       = 32;
   localparam int FRAME_UNITS      = 121;

   // Wide enough to hold the longest phase length (16 units).
   localparam int UNIT_W = 5;

   function automatic logic is_mark(input ir_state_t s);
      return s == LEAD_MARK || s == BIT_MARK || s == STOP_MARK;
   endfunction

   // Sent LSB first: address, ~address, command, ~command.
   function automatic logic [31:0] nec_word(input logic [7:0] address, input logic [7:0] command);
      return {~command, command, ~address, address};
   endfunction

endpackage

// File: rtl/ir_nec_tx_if.sv
// ir_nec_tx_if: request/status bundle of the NEC IR transmitter.
//   start, address, command : requester -> transmitter
//   busy, done, IRDA_TXD    : transmitter -> requester / IR LED
interface ir_nec_tx_if;
   logic       start;
   logic [7:0] address;
   logic [7:0] command;
   logic       busy;
   logic       done;
   logic       IRDA_TXD;

   modport master (output start, address, command, input busy, done, IRDA_TXD);
   modport slave  (input start, address, command, output busy, done, IRDA_TXD);
endinterface

// File: rtl/ir_unit_timer.sv
// ir_unit_timer: NEC unit prescaler plus phase unit counter.
//   clk_pll, reset : clock, synchronous active-high reset
//   restart        : hold counters at zero (used while idle)
//   target         : phase length in NEC units (>= 1)
//   phase_end      : high on the last cycle of the phase; counters restart at 0 after it
module ir_unit_timer import ir_pkg::*; #(
   parameter int TICKS_PER_UNIT = 28125
) (
   input  logic              clk_pll,
   input  logic              reset,
   input  logic              restart,
   input  logic [UNIT_W-1:0] target,
   output logic              phase_end
);

   localparam int PW = TICKS_PER_UNIT > 1 ? $clog2(TICKS_PER_UNIT) : 1;

   logic [PW-1:0]     pre;
   logic [UNIT_W-1:0] units;
   logic              last_tick;

   assign last_tick = pre == PW'(TICKS_PER_UNIT - 1);
   assign phase_end = !restart && last_tick && units == target - UNIT_W'(1);

   always_ff @(posedge clk_pll) begin
      if (reset || restart || phase_end) begin
         pre   <= '0;
         units <= '0;
      end else if (last_tick) begin
         pre   <= '0;
         units <= units + UNIT_W'(1);
      end else begin
         pre   <= pre + PW'(1);
      end
   end

endmodule

// File: rtl/ir_nec_tx.sv
// ir_nec_tx: NEC pulse-distance IR transmitter with optional carrier on marks.
//   clk_pll, reset : clock, synchronous active-high reset
//   tx.start       : frame request, sampled only when idle
//   tx.address/command : latched on accept
//   tx.busy        : frame in progress
//   tx.done        : one-cycle pulse on the first idle cycle after the stop mark
//   tx.IRDA_TXD    : registered IR output, mark = 1 or carrier, space = 0
module ir_nec_tx import ir_pkg::*; #(
   parameter int TICKS_PER_UNIT = 28125,
   parameter bit MODULATE       = 1'b1,
   parameter int CARRIER_HALF   = 658
) (
   input logic        clk_pll,
   input logic        reset,
   ir_nec_tx_if.slave tx
);

   localparam int CW = CARRIER_HALF > 1 ? $clog2(CARRIER_HALF) : 1;

   ir_state_t         state, state_nxt;
   logic [31:0]       shreg;
   logic [4:0]        bit_cnt;
   logic [UNIT_W-1:0] target;
   logic              phase_end;
   logic [CW-1:0]     car_cnt, car_cnt_nxt;
   logic              car, car_nxt, car_wrap, mark_nxt;
   logic              txd, done;

   ir_unit_timer #(.TICKS_PER_UNIT(TICKS_PER_UNIT)) u_timer (
      .clk_pll   (clk_pll),
      .reset     (reset),
      .restart   (state == IDLE),
      .target    (target),
      .phase_end (phase_end)
   );

   always_comb begin
      target = state == LEAD_MARK  ? UNIT_W'(LEAD_MARK_UNITS)  :
               state == LEAD_SPACE ? UNIT_W'(LEAD_SPACE_UNITS) :
               state == BIT_SPACE  ? (shreg[0] ? UNIT_W'(ONE_SPACE_UNITS) : UNIT_W'(ZERO_SPACE_UNITS)) :
               state == STOP_MARK  ? UNIT_W'(STOP_UNITS)       :
                                     UNIT_W'(BIT_MARK_UNITS);
   end

   always_ff @(posedge clk_pll) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:       if (tx.start) state_nxt = LEAD_MARK;
         LEAD_MARK:  if (phase_end) state_nxt = LEAD_SPACE;
         LEAD_SPACE: if (phase_end) state_nxt = BIT_MARK;
         BIT_MARK:   if (phase_end) state_nxt = BIT_SPACE;
         BIT_SPACE:  if (phase_end) state_nxt = bit_cnt == 5'(FRAME_BITS - 1) ? STOP_MARK : BIT_MARK;
         STOP_MARK:  if (phase_end) state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
   end

   // Carrier and TXD are computed for the upcoming state so the output
   // register lines up with the state register. Mark states are never
   // adjacent, so a mark following a non-mark is always a fresh entry.
   always_comb begin
      mark_nxt    = is_mark(state_nxt);
      car_wrap    = car_cnt == CW'(CARRIER_HALF - 1);
      car_cnt_nxt = '0;
      car_nxt     = 1'b1;
      if (mark_nxt && is_mark(state)) begin
         car_cnt_nxt = car_wrap ? '0 : car_cnt + CW'(1);
         car_nxt     = car_wrap ? ~car : car;
      end
   end

   always_ff @(posedge clk_pll) begin
      if (reset) begin
         shreg   <= '0;
         bit_cnt <= '0;
         car_cnt <= '0;
         car     <= 1'b0;
         txd     <= 1'b0;
         done    <= 1'b0;
      end else begin
         done    <= state == STOP_MARK && phase_end;
         car_cnt <= car_cnt_nxt;
         car     <= car_nxt;
         txd     <= mark_nxt && (!MODULATE || car_nxt);
         if (state == IDLE && tx.start) begin
            shreg   <= nec_word(tx.address, tx.command);
            bit_cnt <= '0;
         end else if (state == BIT_SPACE && phase_end) begin
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 5'd1;
         end
      end
   end

   assign tx.busy     = state != IDLE;
   assign tx.done     = done;
   assign tx.IRDA_TXD = txd;

endmodule
